// File: rtl/pool1_requant_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pool1_requant_pkg                                         |
// | Purpose  : Shared types and constants for the pool1 requant block:   |
// |            pooled-dimension derivation, saturation bounds and the    |
// |            streaming state encoding.                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pool1_requant_pkg;

   // 2x2 / stride-2 pooling keeps floor(n/2); an odd trailing row/column
   // has no partner and is dropped.
   function automatic int pool_dim(input int n);
      return n / 2;
   endfunction

   localparam logic [7:0] c_sat_min = 8'd0;
   localparam logic [7:0] c_sat_max = 8'd255;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

endpackage : pool1_requant_pkg
`default_nettype wire

// File: rtl/pool1_window_max.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pool1_window_max                                          |
// | Purpose  : Combinational 2x2 window max (signed 24-bit) followed by  |
// |            arithmetic right shift and unsigned 8-bit saturation.     |
// | Ports    : i_e00..i_e11  four signed window elements                 |
// |            o_q           saturated requantized result                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pool1_window_max
   import pool1_requant_pkg::*;
#(
   parameter int SHIFT = 8
) (
   input  logic signed [23:0] i_e00,
   input  logic signed [23:0] i_e01,
   input  logic signed [23:0] i_e10,
   input  logic signed [23:0] i_e11,
   output logic        [7:0]  o_q
);

   logic signed [23:0] w_max_top;
   logic signed [23:0] w_max_bot;
   logic signed [23:0] w_max;
   logic signed [23:0] w_shr;

   assign w_max_top = (i_e00 > i_e01) ? i_e00 : i_e01;
   assign w_max_bot = (i_e10 > i_e11) ? i_e10 : i_e11;
   assign w_max     = (w_max_top > w_max_bot) ? w_max_top : w_max_bot;
   assign w_shr     = w_max >>> SHIFT;

   always_comb begin
      o_q = w_shr[7:0];
      if (w_shr < 24'sd0) begin
         o_q = c_sat_min;
      end else if (w_shr > $signed({16'd0, c_sat_max})) begin
         o_q = c_sat_max;
      end
   end

endmodule : pool1_window_max
`default_nettype wire

// File: rtl/pool1_requant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pool1_requant                                             |
// | Purpose  : Snapshots a conv1 feature map on each rising edge of      |
// |            in_valid, 2x2 max-pools it, requantizes to u8 and streams |
// |            the pooled map out over valid/ready.                      |
// | Ports    : in_valid/in_chan/in_map   conv1 map input (level valid)   |
// |            out_valid/out_ready       output handshake                |
// |            out_data/chan/row/col/last pooled element and tags        |
// |            busy, overflow            status (overflow is sticky)     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pool1_requant
   import pool1_requant_pkg::*;
#(
   parameter int OUT_H = 14,
   parameter int OUT_W = 13,
   parameter int SHIFT = 8,
   parameter int PH    = pool_dim(OUT_H),
   parameter int PW    = pool_dim(OUT_W)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [3:0]                in_chan,
   input  logic [OUT_H*OUT_W*24-1:0] in_map,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_data,
   output logic [3:0]                out_chan,
   output logic [2:0]                out_row,
   output logic [2:0]                out_col,
   output logic                      out_last,
   output logic                      busy,
   output logic                      overflow
);

   localparam logic [2:0] c_last_row = 3'(PH - 1);
   localparam logic [2:0] c_last_col = 3'(PW - 1);

   state_t                      r_state;
   logic                        r_prev_valid;
   logic [OUT_H*OUT_W*24-1:0]   r_snap;
   logic [3:0]                  r_chan;
   logic                        r_out_valid;
   logic [7:0]                  r_out_data;
   logic [2:0]                  r_out_row;
   logic [2:0]                  r_out_col;
   logic                        r_out_last;
   logic                        r_overflow;

   logic                        w_rise;
   logic                        w_xfer;
   logic                        w_final;
   logic                        w_accept;
   logic [2:0]                  w_nxt_row;
   logic [2:0]                  w_nxt_col;
   logic [2:0]                  w_sel_row;
   logic [2:0]                  w_sel_col;
   logic                        w_sel_last;
   logic [OUT_H*OUT_W*24-1:0]   w_src;
   int                          w_base;
   logic signed [23:0]          w_e00, w_e01, w_e10, w_e11;
   logic [7:0]                  w_q;

   assign w_rise  = in_valid & ~r_prev_valid;
   assign w_xfer  = r_out_valid & out_ready;
   assign w_final = w_xfer & r_out_last;
   // A new map is taken when idle, or in the very cycle the last element
   // leaves so back-to-back maps stream without a bubble.
   assign w_accept = w_rise & ((r_state == ST_IDLE) | w_final);

   assign w_nxt_col = (r_out_col == c_last_col) ? 3'd0 : r_out_col + 3'd1;
   assign w_nxt_row = (r_out_col == c_last_col) ? r_out_row + 3'd1 : r_out_row;

   // The output register is loaded either from the incoming map (entry)
   // or from the snapshot (advance), so the window source is muxed.
   assign w_sel_row  = w_accept ? 3'd0 : w_nxt_row;
   assign w_sel_col  = w_accept ? 3'd0 : w_nxt_col;
   assign w_sel_last = (w_sel_row == c_last_row) && (w_sel_col == c_last_col);
   assign w_src      = w_accept ? in_map : r_snap;

   always_comb begin
      w_base = ((2 * int'(w_sel_row)) * OUT_W + 2 * int'(w_sel_col)) * 24;
      w_e00  = w_src[w_base                  +: 24];
      w_e01  = w_src[w_base + 24             +: 24];
      w_e10  = w_src[w_base + OUT_W * 24     +: 24];
      w_e11  = w_src[w_base + OUT_W * 24 + 24 +: 24];
   end

   pool1_window_max #(
      .SHIFT (SHIFT)
   ) u_window_max (
      .i_e00 (w_e00),
      .i_e01 (w_e01),
      .i_e10 (w_e10),
      .i_e11 (w_e11),
      .o_q   (w_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_prev_valid <= 1'b0;
         r_snap       <= '0;
         r_chan       <= 4'd0;
         r_out_valid  <= 1'b0;
         r_out_data   <= 8'd0;
         r_out_row    <= 3'd0;
         r_out_col    <= 3'd0;
         r_out_last   <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_prev_valid <= in_valid;
         if (w_rise && (r_state == ST_STREAM) && !w_final) begin
            r_overflow <= 1'b1;
         end
         if (w_accept) begin
            r_state     <= ST_STREAM;
            r_snap      <= in_map;
            r_chan      <= in_chan;
            r_out_valid <= 1'b1;
            r_out_data  <= w_q;
            r_out_row   <= w_sel_row;
            r_out_col   <= w_sel_col;
            r_out_last  <= w_sel_last;
         end else if (w_xfer) begin
            if (r_out_last) begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end else begin
               r_out_data <= w_q;
               r_out_row  <= w_sel_row;
               r_out_col  <= w_sel_col;
               r_out_last <= w_sel_last;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_chan;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;
   assign out_last  = r_out_last;
   assign busy      = (r_state == ST_STREAM);
   assign overflow  = r_overflow;

endmodule : pool1_requant
`default_nettype wire
